decode_queue: RTL and testbench

//  Buffered, multi-lane MIPS main decoder between fetch and issue. Accepts up to FETCH_W

---
 rtl/decode_pkg.sv | 61 ++++++
 rtl/main_dec_lane.sv | 80 ++++++++
 rtl/decode_queue.sv | 112 +++++++++++
 tb/tb_decode_queue.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared control-bundle type and MIPS opcode/funct constants for decode_queue.
// The DECODE_RI_EN macro makes main_dec_lane use is_alu_fn to flag reserved encodings.
package decode_pkg;

    typedef struct packed {
        logic [4:0] branch;
        logic [1:0] jump;
        logic [1:0] jumpreg;
        logic [1:0] exception;
        logic [2:0] move;
        logic [4:0] memory;
        logic [5:0] machine;
        logic [2:0] itype;
        logic       ri;
    } ctrl_t;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_COP0    = 6'b010000;

    localparam logic [2:0] OPG_ALUI   = 3'b001;
    localparam logic [2:0] OPG_LOAD   = 3'b100;
    localparam logic [2:0] OPG_STORE  = 3'b101;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;
    localparam logic [5:0] FN_BREAK   = 6'b001101;
    localparam logic [5:0] FN_MFHI    = 6'b010000;
    localparam logic [5:0] FN_MTHI    = 6'b010001;
    localparam logic [5:0] FN_MFLO    = 6'b010010;
    localparam logic [5:0] FN_MTLO    = 6'b010011;
    localparam logic [2:0] FN_ERET_HI = 3'b011;

    localparam logic [2:0] TYPE_R   = 3'b000;
    localparam logic [2:0] TYPE_I   = 3'b001;
    localparam logic [2:0] TYPE_JR  = 3'b010;
    localparam logic [2:0] TYPE_MOV = 3'b011;
    localparam logic [2:0] TYPE_MEM = 3'b100;
    localparam logic [2:0] TYPE_EXC = 3'b101;
    localparam logic [2:0] TYPE_CP0 = 3'b110;
    localparam logic [2:0] TYPE_RI  = 3'b111;

    // Plain R-type ALU/shift/mul-div funct codes that decode as ordinary TYPE_R.
    function automatic logic is_alu_fn(input logic [5:0] fn);
        case (fn)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
            6'h18, 6'h19, 6'h1A, 6'h1B,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B: return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/main_dec_lane.sv
// Combinational MIPS main decoder for one issue lane: instruction word -> ctrl_t.
// With DECODE_RI_EN defined, unlisted opcodes and unknown SPECIAL functs set ri/TYPE_RI.
module main_dec_lane
    import decode_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       unusedBits;

    assign op         = instr_i[31:26];
    assign fn         = instr_i[5:0];
    assign unusedBits = ^instr_i;

    always_comb begin
        ctrl_o = '0;
        case (op)
            OP_SPECIAL: begin
                case (fn)
                    FN_JR, FN_JALR: begin
                        ctrl_o.jumpreg = {1'b1, fn[0]};
                        ctrl_o.itype   = TYPE_JR;
                    end
                    FN_SYSCALL, FN_BREAK: begin
                        ctrl_o.exception = {1'b1, fn[0]};
                        ctrl_o.itype     = TYPE_EXC;
                    end
                    FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO: begin
                        ctrl_o.move  = {1'b1, fn[1:0]};
                        ctrl_o.itype = TYPE_MOV;
                    end
                    default: begin
                        ctrl_o.itype = TYPE_R;
`ifdef DECODE_RI_EN
                        if (!is_alu_fn(fn)) begin
                            ctrl_o.ri    = 1'b1;
                            ctrl_o.itype = TYPE_RI;
                        end
`endif
                    end
                endcase
            end
            // rt[0] picks GEZ over LTZ, rt[4] adds the link.
            OP_REGIMM: ctrl_o.branch = {2'b11, instr_i[16], 1'b0, instr_i[20]};
            OP_J, OP_JAL: ctrl_o.jump = {1'b1, op[0]};
            OP_BEQ:    ctrl_o.branch = 5'b10000;
            OP_BNE:    ctrl_o.branch = 5'b10100;
            OP_BLEZ:   ctrl_o.branch = 5'b11000;
            OP_BGTZ:   ctrl_o.branch = 5'b11110;
            OP_COP0: begin
                if (fn[5:3] == FN_ERET_HI) begin
                    ctrl_o.machine = 6'b110000;
                end else begin
                    ctrl_o.machine = {2'b10, instr_i[23], instr_i[2:0]};
                end
                ctrl_o.itype = TYPE_CP0;
            end
            default: begin
                if (op[5:3] == OPG_ALUI) begin
                    ctrl_o.itype = TYPE_I;
                end else if (op[5:3] == OPG_LOAD) begin
                    ctrl_o.memory = {2'b10, op[1:0], op[2]};
                    ctrl_o.itype  = TYPE_MEM;
                end else if (op[5:3] == OPG_STORE) begin
                    ctrl_o.memory = {2'b11, op[1:0], 1'b0};
                    ctrl_o.itype  = TYPE_MEM;
                end else begin
`ifdef DECODE_RI_EN
                    ctrl_o.ri    = 1'b1;
                    ctrl_o.itype = TYPE_RI;
`endif
                end
            end
        endcase
    end

endmodule

// File: rtl/decode_queue.sv
// Circular instruction queue between fetch and issue, decoding the ISSUE_W oldest entries.
// Reserved-instruction flagging is enabled by defining DECODE_RI_EN (see main_dec_lane).
module decode_queue
    import decode_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [$clog2(FETCH_W+1)-1:0] in_count,
    input  logic [FETCH_W*32-1:0]        in_instr,
    input  logic [FETCH_W*32-1:0]        in_pc,
    output logic                         in_ready,
    output logic [ISSUE_W-1:0]           out_valid,
    output logic [ISSUE_W*32-1:0]        out_pc,
    output ctrl_t [ISSUE_W-1:0]          out_ctrl,
    input  logic                         out_ready
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CIW = $clog2(FETCH_W + 1);

    logic [31:0]   instrMem_q [DEPTH];
    logic [31:0]   pcMem_q    [DEPTH];
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] popCount;
    logic          pushFire;
    logic          popFire;

    // Registered count only, so out_ready never reaches in_ready combinationally.
    assign in_ready = (count_q <= CW'(DEPTH - FETCH_W));
    assign pushFire = in_valid && in_ready && !flush;
    assign popFire  = out_ready && !flush;

    always_comb begin
        out_valid = '0;
        popCount  = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            out_valid[i] = !flush && (count_q > CW'(i));
            if (out_valid[i]) begin
                popCount = popCount + CW'(1);
            end
        end
    end

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (flush) begin
            rdPtr_d = wrPtr_q;
            count_d = '0;
        end else begin
            if (pushFire) begin
                wrPtr_d = wrPtr_q + PW'(in_count);
                count_d = count_d + CW'(in_count);
            end
            if (popFire) begin
                rdPtr_d = rdPtr_q + PW'(popCount);
                count_d = count_d - popCount;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pushFire) begin
            for (int i = 0; i < FETCH_W; i++) begin
                if (CIW'(i) < in_count) begin
                    instrMem_q[wrPtr_q + PW'(i)] <= in_instr[i*32 +: 32];
                    pcMem_q[wrPtr_q + PW'(i)]    <= in_pc[i*32 +: 32];
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!reset && in_valid) begin
            assert (in_count <= CIW'(FETCH_W));
        end
    end

    // Lane addresses wrap independently, so one issue group may straddle the array end.
    for (genvar g = 0; g < ISSUE_W; g++) begin : gLane
        logic [PW-1:0] rdAddr;
        assign rdAddr              = rdPtr_q + PW'(g);
        assign out_pc[g*32 +: 32]  = pcMem_q[rdAddr];
        main_dec_lane uDec (
            .instr_i (instrMem_q[rdAddr]),
            .ctrl_o  (out_ctrl[g])
        );
    end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: scoreboard of expected PC/ctrl per pushed instruction.
// Expected ri behaviour follows DECODE_RI_EN, matching the build of the design.
module tb_decode_queue;
    import decode_pkg::*;

    localparam int DEPTH   = 8;
    localparam int FETCH_W = 2;
    localparam int ISSUE_W = 2;

    typedef struct packed {
        logic [31:0] pc;
        ctrl_t       ctrl;
    } sbEntry_t;

    logic                 clk;
    logic                 reset;
    logic                 flush;
    logic                 in_valid;
    logic [1:0]           in_count;
    logic [FETCH_W*32-1:0] in_instr;
    logic [FETCH_W*32-1:0] in_pc;
    logic                 in_ready;
    logic [ISSUE_W-1:0]   out_valid;
    logic [ISSUE_W*32-1:0] out_pc;
    ctrl_t [ISSUE_W-1:0]  out_ctrl;
    logic                 out_ready;

    sbEntry_t    sb[$];
    logic [31:0] tInstr [20];
    ctrl_t       tCtrl  [20];
    logic [31:0] pcCtr;
    int          nCompared;
    int          nMismatched;

    decode_queue #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_count  (in_count),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_ctrl  (out_ctrl),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctrl_t mkCtrl(input logic [4:0] br, input logic [1:0] jp,
                                     input logic [1:0] jr, input logic [1:0] ex,
                                     input logic [2:0] mv, input logic [4:0] mem,
                                     input logic [5:0] mc, input logic [2:0] ty);
        ctrl_t c;
        c           = '0;
        c.branch    = br;
        c.jump      = jp;
        c.jumpreg   = jr;
        c.exception = ex;
        c.move      = mv;
        c.memory    = mem;
        c.machine   = mc;
        c.itype     = ty;
        return c;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check outputs against the scoreboard, update the model, clock.
    task automatic applyStimulus(input bit v, input int cnt, input int a, input int b,
                                 input bit rdy, input bit fl);
        int                 sz;
        int                 popN;
        logic [ISSUE_W-1:0] expValid;
        sbEntry_t           e;
        in_valid  = v;
        in_count  = 2'(cnt);
        in_instr  = {tInstr[b], tInstr[a]};
        in_pc     = {pcCtr + 32'd4, pcCtr};
        out_ready = rdy;
        flush     = fl;
        #1;
        sz = sb.size();
        checkOutput("in_ready", 64'(in_ready), 64'(sz <= DEPTH - FETCH_W));
        for (int i = 0; i < ISSUE_W; i++) expValid[i] = !fl && (sz > i);
        checkOutput("out_valid", 64'(out_valid), 64'(expValid));
        if (rdy && !fl) begin
            popN = (sz < ISSUE_W) ? sz : ISSUE_W;
            for (int i = 0; i < popN; i++) begin
                e = sb.pop_front();
                checkOutput($sformatf("lane%0d_pc", i), 64'(out_pc[i*32 +: 32]), 64'(e.pc));
                checkOutput($sformatf("lane%0d_ctrl", i), 64'(out_ctrl[i]), 64'(e.ctrl));
            end
        end
        if (fl) begin
            sb.delete();
        end else if (v && sz <= DEPTH - FETCH_W) begin
            if (cnt >= 1) sb.push_back('{pc: pcCtr, ctrl: tCtrl[a]});
            if (cnt >= 2) sb.push_back('{pc: pcCtr + 32'd4, ctrl: tCtrl[b]});
        end
        if (v) pcCtr = pcCtr + 32'd8;
        @(posedge clk);
        #1;
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        pcCtr       = 32'h0000_1000;
        tInstr[0]  = 32'h03E00008; tCtrl[0]  = mkCtrl(5'b0, 2'b0, 2'b10, 2'b0, 3'b0, 5'b0, 6'b0, 3'b010);
        tInstr[1]  = 32'h8C220004; tCtrl[1]  = mkCtrl(5'b0, 2'b0, 2'b0, 2'b0, 3'b0, 5'b10110, 6'b0, 3'b100);
        tInstr[2]  = 32'h90430001; tCtrl[2]  = mkCtrl(5'b0, 2'b0, 2'b0, 2'b0, 3'b0, 5'b10001, 6'b0, 3'b100);
        tInstr[3]  = 32'h20010001; tCtrl[3]  = mkCtrl(5'b0, 2'b0, 2'b0, 2'b0, 3'b0, 5'b0, 6'b0, 3'b001);
        tInstr[4]  = 32'h08000010; tCtrl[4]  = mkCtrl(5'b0, 2'b10, 2'b0, 2'b0, 3'b0, 5'b0, 6'b0, 3'b000);
        tInstr[5]  = 32'h10220003; tCtrl[5]  = mkCtrl(5'b10000, 2'b0, 2'b0, 2'b0, 3'b0, 5'b0, 6'b0, 3'b000);
        tInstr[6]  = 32'hAC220008; tCtrl[6]  = mkCtrl(5'b0, 2'b0, 2'b0, 2'b0, 3'b0, 5'b11110, 6'b0, 3'b100);
        tInstr[7]  = 32'h0C000004; tCtrl[7]  = mkCtrl(5'b0, 2'b11, 2'b0, 2'b0, 3'b0, 5'b0, 6'b0, 3'b000);
        tInstr[8]  = 32'h1C200002; tCtrl[8]  = mkCtrl(5'b11110, 2'b0, 2'b0, 2'b0, 3'b0, 5'b0, 6'b0, 3'b000);
        tInstr[9]  = 32'h00001012; tCtrl[9]  = mkCtrl(5'b0, 2'b0, 2'b0, 2'b0, 3'b110, 5'b0, 6'b0, 3'b011);
        tInstr[10] = 32'h0000000C; tCtrl[10] = mkCtrl(5'b0, 2'b0, 2'b0, 2'b10, 3'b0, 5'b0, 6'b0, 3'b101);
        tInstr[11] = 32'h04310005; tCtrl[11] = mkCtrl(5'b11101, 2'b0, 2'b0, 2'b0, 3'b0, 5'b0, 6'b0, 3'b000);
        tInstr[12] = 32'h42000018; tCtrl[12] = mkCtrl(5'b0, 2'b0, 2'b0, 2'b0, 3'b0, 5'b0, 6'b110000, 3'b110);
        tInstr[13] = 32'h40826000; tCtrl[13] = mkCtrl(5'b0, 2'b0, 2'b0, 2'b0, 3'b0, 5'b0, 6'b101000, 3'b110);
        tInstr[14] = 32'h0000000D; tCtrl[14] = mkCtrl(5'b0, 2'b0, 2'b0, 2'b11, 3'b0, 5'b0, 6'b0, 3'b101);
        tInstr[15] = 32'h0040F809; tCtrl[15] = mkCtrl(5'b0, 2'b0, 2'b11, 2'b0, 3'b0, 5'b0, 6'b0, 3'b010);
        tInstr[16] = 32'h00221820; tCtrl[16] = '0;
        tInstr[17] = 32'h04200003; tCtrl[17] = mkCtrl(5'b11000, 2'b0, 2'b0, 2'b0, 3'b0, 5'b0, 6'b0, 3'b000);
        tInstr[18] = 32'h94430002; tCtrl[18] = mkCtrl(5'b0, 2'b0, 2'b0, 2'b0, 3'b0, 5'b10011, 6'b0, 3'b100);
        tInstr[19] = 32'hFC000000;
`ifdef DECODE_RI_EN
        tCtrl[19]    = mkCtrl(5'b0, 2'b0, 2'b0, 2'b0, 3'b0, 5'b0, 6'b0, 3'b111);
        tCtrl[19].ri = 1'b1;
`else
        tCtrl[19]    = '0;
`endif

        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_count  = '0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        #3 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] reset state");
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] single JR, one-cycle latency, then empty");
        applyStimulus(1, 1, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);

        $display("[TB] LW + LBU pair");
        applyStimulus(1, 2, 1, 2, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);

        $display("[TB] fill to count 7, in_ready drops even with pop pending");
        applyStimulus(1, 1, 3, 3, 0, 0);
        applyStimulus(1, 2, 4, 5, 0, 0);
        applyStimulus(1, 2, 6, 7, 0, 0);
        applyStimulus(1, 2, 8, 9, 0, 0);
        applyStimulus(1, 2, 10, 11, 0, 0);
        applyStimulus(1, 2, 10, 11, 1, 0);
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 0, 1, 0);

        $display("[TB] push2/pop2 streaming across pointer wrap");
        applyStimulus(1, 1, 12, 12, 1, 0);
        for (int k = 0; k < 20; k++) applyStimulus(1, 2, (2 * k) % 19, (2 * k + 1) % 19, 1, 0);
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 1, 0);

        $display("[TB] flush at count 5 with a push offered");
        applyStimulus(1, 1, 13, 13, 0, 0);
        applyStimulus(1, 2, 14, 15, 0, 0);
        applyStimulus(1, 2, 16, 17, 0, 0);
        applyStimulus(1, 2, 18, 3, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, 15, 15, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);

        $display("[TB] reserved opcode 0xFC000000");
        applyStimulus(1, 1, 19, 19, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);

        $display("[TB] asynchronous reset mid-operation");
        applyStimulus(1, 2, 1, 2, 0, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("async_rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("async_rst_in_ready", 64'(in_ready), 64'(1));
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, 9, 9, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
